// File: rtl/alu_pkg.sv
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared ALU datapath constants and saturation-bound helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    localparam int unsigned SAT_MAX_W = 128;

    // Signed MAX (neg=0) or MIN (neg=1) for a w-bit word, LSB-aligned.
    function automatic logic [SAT_MAX_W-1:0] sat_bound(input int unsigned w, input logic neg);
        logic [SAT_MAX_W-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < SAT_MAX_W; i++) begin
            if (i + 1 < w) begin
                v[i] = ~neg;
            end else if (i + 1 == w) begin
                v[i] = neg;
            end
        end
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg_adder.sv
// ============================================================================
//  Module      : seg_adder
//  Description : W-bit ripple adder segment exposing the carry into its MSB.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         c_msb_in
);

    logic [W:0] w_full;

    always_comb begin
        w_full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    end

    assign s        = w_full[W-1:0];
    assign cout     = w_full[W];
    assign c_msb_in = a[W-1] ^ b[W-1] ^ w_full[W-1];

endmodule

`default_nettype wire

// File: rtl/pipelined_add_sub.sv
// ============================================================================
//  Module      : pipelined_add_sub
//  Description : Segmented-carry pipelined add/sub with saturation and
//                valid/ready back-pressure.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_add_sub
    import alu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int SEGMENTS = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             add_sub,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int SEG_W = WIDTH / SEGMENTS;

    if (SEGMENTS < 1 || (WIDTH % SEGMENTS) != 0) begin : g_bad_cfg
        $error("pipelined_add_sub: WIDTH must be a multiple of SEGMENTS and SEGMENTS >= 1");
    end

    logic             w_advance;
    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             c_out_q;
    logic             ovf_q;
    logic             zero_q;

    assign w_advance = !out_valid_q || out_ready;

    for (genvar s = 0; s < SEGMENTS; s++) begin : g_stage
        // Operand bits still waiting for this and later stages.
        localparam int PIN = WIDTH - s * SEG_W;

        logic [PIN-1:0]             src_a;
        logic [PIN-1:0]             src_b;
        logic                       src_c;
        logic                       src_sat;
        logic                       src_z;
        logic                       src_v;
        logic [SEG_W-1:0]           seg_sum;
        logic                       seg_cout;
        logic                       seg_cmsb;
        logic [(s+1)*SEG_W-1:0]     res;

        if (s == 0) begin : g_src_in
            assign src_a   = in1;
            assign src_b   = (add_sub == SUB) ? ~in2 : in2;
            assign src_c   = add_sub;
            assign src_sat = sat;
            assign src_z   = 1'b1;
            assign src_v   = in_valid;
            assign res     = seg_sum;
        end else begin : g_src_prev
            assign src_a   = g_stage[s-1].g_mid.a_q;
            assign src_b   = g_stage[s-1].g_mid.b_q;
            assign src_c   = g_stage[s-1].g_mid.carry_q;
            assign src_sat = g_stage[s-1].g_mid.sat_q;
            assign src_z   = g_stage[s-1].g_mid.zacc_q;
            assign src_v   = g_stage[s-1].g_mid.valid_q;
            assign res     = {seg_sum, g_stage[s-1].g_mid.r_q};
        end

        seg_adder #(.W(SEG_W)) u_seg (
            .a        (src_a[SEG_W-1:0]),
            .b        (src_b[SEG_W-1:0]),
            .cin      (src_c),
            .s        (seg_sum),
            .cout     (seg_cout),
            .c_msb_in (seg_cmsb)
        );

        if (s < SEGMENTS - 1) begin : g_mid
            logic                   valid_q, valid_d;
            logic                   carry_q, carry_d;
            logic                   sat_q, sat_d;
            logic                   zacc_q, zacc_d;
            logic [PIN-SEG_W-1:0]   a_q, a_d;
            logic [PIN-SEG_W-1:0]   b_q, b_d;
            logic [(s+1)*SEG_W-1:0] r_q, r_d;
            logic                   unused_cmsb;

            assign unused_cmsb = seg_cmsb;

            always_comb begin
                valid_d = src_v;
                carry_d = seg_cout;
                sat_d   = src_sat;
                zacc_d  = src_z && (seg_sum == '0);
                a_d     = src_a[PIN-1:SEG_W];
                b_d     = src_b[PIN-1:SEG_W];
                r_d     = res;
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    valid_q <= 1'b0;
                    carry_q <= 1'b0;
                    sat_q   <= 1'b0;
                    zacc_q  <= 1'b0;
                    a_q     <= '0;
                    b_q     <= '0;
                    r_q     <= '0;
                end else if (w_advance) begin
                    valid_q <= valid_d;
                    carry_q <= carry_d;
                    sat_q   <= sat_d;
                    zacc_q  <= zacc_d;
                    a_q     <= a_d;
                    b_q     <= b_d;
                    r_q     <= r_d;
                end
            end
        end else begin : g_last
            logic             ovf_raw;
            logic             sat_hit;
            logic             out_valid_d;
            logic [WIDTH-1:0] sum_d;
            logic             c_out_d;
            logic             ovf_d;
            logic             zero_d;

            // Saturated values are never zero, so the accumulator only
            // decides when the raw sum passes through.
            always_comb begin
                ovf_raw     = seg_cmsb ^ seg_cout;
                sat_hit     = src_sat && ovf_raw;
                out_valid_d = src_v;
                c_out_d     = seg_cout;
                ovf_d       = ovf_raw;
                sum_d       = res;
                zero_d      = src_z && (seg_sum == '0);
                if (sat_hit) begin
                    sum_d  = WIDTH'(sat_bound(WIDTH, src_a[PIN-1]));
                    zero_d = 1'b0;
                end
            end

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    out_valid_q <= 1'b0;
                    sum_q       <= '0;
                    c_out_q     <= 1'b0;
                    ovf_q       <= 1'b0;
                    zero_q      <= 1'b0;
                end else if (w_advance) begin
                    out_valid_q <= out_valid_d;
                    sum_q       <= sum_d;
                    c_out_q     <= c_out_d;
                    ovf_q       <= ovf_d;
                    zero_q      <= zero_d;
                end
            end
        end
    end

    assign in_ready  = w_advance;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_pipelined_add_sub.sv
// ============================================================================
//  Module      : tb_pipelined_add_sub
//  Description : Scoreboard bench for pipelined_add_sub (32-bit, 4 segments).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipelined_add_sub;

    localparam int W = 32;
    localparam int S = 4;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    logic         add_sub = 1'b0;
    logic         sat = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;
    logic         zero;

    typedef struct {
        logic [W-1:0] sum;
        logic         c;
        logic         o;
        logic         z;
        int           cyc;
        bit           lat;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   ready_mode = 1'b0;
    bit   ready_hold = 1'b1;
    bit   cnt_en = 1'b0;
    int   low_cnt = 0;

    pipelined_add_sub #(.WIDTH(W), .SEGMENTS(S)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .add_sub   (add_sub),
        .sat       (sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    // Reference: signed/unsigned integer arithmetic on wide values.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic op, input logic s);
        exp_t e;
        longint sa, sb, r;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        r  = op ? (sa - sb) : (sa + sb);
        e.o = (r > SMAX) || (r < SMIN);
        e.c = op ? (ua >= ub) : (((ua + ub) >> 32) != 0);
        e.sum = (e.o && s) ? (a[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF) : r[W-1:0];
        e.z = (e.sum == '0);
        e.cyc = 0;
        e.lat = 1'b0;
        return e;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    initial begin : ready_drv
        forever begin
            @(posedge clock);
            #1;
            out_ready = ready_mode ? ($urandom_range(0, 3) != 0) : ready_hold;
        end
    end

    // Monitor: pops the scoreboard whenever a result transfers.
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_sum = '0;
    logic [2:0]   prev_fl = '0;
    exp_t         m_e;

    always @(negedge clock) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            chk("in_ready", {63'b0, in_ready}, {63'b0, (!out_valid || out_ready)});
            if (prev_stall)
                chk("stall_hold", {28'b0, out_valid, sum, c_out, ovf, zero},
                    {28'b0, 1'b1, prev_sum, prev_fl});
            if (cnt_en && !in_ready) low_cnt++;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_result: sum=%0h appeared with no beat outstanding", sum);
                end else begin
                    m_e = q.pop_front();
                    chk("result", {29'b0, sum, c_out, ovf, zero},
                        {29'b0, m_e.sum, m_e.c, m_e.o, m_e.z});
                    if (m_e.lat) chk("latency", 64'(cyc - m_e.cyc), 64'(S));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_sum   = sum;
            prev_fl    = {c_out, ovf, zero};
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic op, input logic s, input bit lat);
        int   waited;
        exp_t e;
        waited   = 0;
        in_valid = 1'b1;
        in1      = a;
        in2      = b;
        add_sub  = op;
        sat      = s;
        @(negedge clock);
        while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clock);
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready=0 after 200 cycles, required 1");
        end else begin
            e = model(a, b, op, s);
            e.cyc = cyc;
            e.lat = lat;
            q.push_back(e);
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 500) begin
            @(negedge clock);
            t++;
        end
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
            q.delete();
        end
        @(posedge clock);
        #1;
    endtask

    initial begin : main
        #1 reset = 1'b1;
        #11;
        chk("reset_out_valid", {63'b0, out_valid}, 64'd0);
        chk("reset_outputs", {29'b0, sum, c_out, ovf, zero}, 64'd0);
        chk("reset_in_ready", {63'b0, in_ready}, 64'd1);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1); wait_drain();
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b1); wait_drain();
        send(32'h0000_0005, 32'h0000_0005, 1'b1, 1'b0, 1'b1); wait_drain();
        send(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b1); wait_drain();
        send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b1); wait_drain();

        // Back-to-back stream with a 3-cycle consumer stall.
        cnt_en  = 1'b1;
        low_cnt = 0;
        fork
            begin
                for (int i = 1; i <= 8; i++) send(W'(i), W'(i), 1'b0, 1'b0, 1'b0);
            end
            begin
                repeat (6) @(posedge clock);
                ready_hold = 1'b0;
                repeat (3) @(posedge clock);
                ready_hold = 1'b1;
            end
        join
        wait_drain();
        cnt_en = 1'b0;
        chk("stall_in_ready_low_cycles", 64'(low_cnt), 64'd3);

        // Reset with three beats in flight, one parked at the output.
        ready_hold = 1'b0;
        @(posedge clock);
        #2;
        for (int i = 0; i < 3; i++) send(W'(100 + i), W'(1), 1'b0, 1'b0, 1'b0);
        @(posedge clock);
        #2;
        chk("inflight_out_valid", {63'b0, out_valid}, 64'd1);
        reset = 1'b1;
        #1;
        chk("async_reset_out_valid", {63'b0, out_valid}, 64'd0);
        chk("async_reset_outputs", {29'b0, sum, c_out, ovf, zero}, 64'd0);
        chk("async_reset_in_ready", {63'b0, in_ready}, 64'd1);
        q.delete();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        ready_hold = 1'b1;
        repeat (12) @(negedge clock);

        // Randomized traffic with random back-pressure and idle gaps.
        @(posedge clock);
        #1;
        ready_mode = 1'b1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clock);
                #1;
            end
            send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end
        ready_mode = 1'b0;
        ready_hold = 1'b1;
        wait_drain();
        repeat (3) @(posedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipelined_add_sub.md
# pipelined_add_sub

Parametrised, pipelined two's-complement adder/subtractor for the ALU datapath. It generalises the single-cycle 32-bit add/sub:
- width and pipeline depth are parameters;
- the carry chain is split into segments, one per stage;
- optional signed saturation;
- valid/ready handshake with back-pressure.

It sits between operand select and the ALU result mux, and accepts one operation per cycle.

## Interface
- `WIDTH`, 32: operand/result width in bits.
- `SEGMENTS`, 4: pipeline stages. Each stage adds `SEG_W = WIDTH/SEGMENTS` bits. `WIDTH % SEGMENTS` must be 0 and `SEGMENTS >= 1`; an elaboration error is raised otherwise.
- `clock`  in  1: sole clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: operand beat present.
- `in_ready`  out  1: block accepts a beat this cycle.
- `in1`  in  WIDTH: first operand.
- `in2`  in  WIDTH: second operand.
- `add_sub`  in  1: 0 = `in1+in2`, 1 = `in1-in2`.
- `sat`  in  1: 1 = clamp signed overflow to MAX/MIN.
- `out_valid`  out  1: result beat present.
- `out_ready`  in  1: consumer takes the result this cycle.
- `sum`  out  WIDTH: result.
- `c_out`  out  1: carry out of the MSB. For subtract, 1 means no borrow.
- `ovf`  out  1: signed overflow of the unsaturated result.
- `zero`  out  1: final `sum` (after saturation) is all zeros.

## Operation
- **Subtraction:** computed as `in1 + ~in2 + 1`. `add_sub` drives both the inversion of `in2` and the stage-0 carry-in.
- **Segment pipeline:** stage s adds bits `[s*SEG_W +: SEG_W]` of `in1` and the processed `in2`, using the carry registered by stage s-1.
  - Higher operand segments travel skewed through the stage registers until their stage.
  - Lower result segments travel with them after they are computed.
- **Per-stage state:** each stage holds valid, carry, partial sum, pending operand slices, `sat`, and a running zero accumulator.
- **Flags, taken from the last stage:**
  - `c_out` = carry out of bit `WIDTH-1`.
  - `ovf` = carry into bit `WIDTH-1` XOR carry out of bit `WIDTH-1`.
- **Saturation:** if `sat` and `ovf`, then `sum` = `{0,1…1}` when the `in1` sign bit is 0, else `{1,0…0}`. `ovf` and `c_out` still report the raw add.
- **`zero`:** evaluated on the post-saturation `sum`.
- **Width rule:** no sign extension. All arithmetic is modulo 2^WIDTH.
- **Handshake:**
  - The pipeline advances iff `!out_valid || out_ready`, and `in_ready` equals that term. The combinational `out_ready`→`in_ready` path is accepted.
  - A beat is accepted when `in_valid && in_ready`.
  - If the pipeline advances with `in_valid` low, stage 0 loads a bubble.
- **Stall:** while `out_valid && !out_ready`, every stage register holds.
  - Bubbles are not collapsed.
  - `sum` and all flags stay stable.
- **Ordering:** results emerge in acceptance order. Beats are never dropped or duplicated.
- **Reset:** asserting `reset` at any time clears every stage valid, carry, data and flag register to 0. In-flight beats are discarded. Outputs read `out_valid=0`, `sum=0`, `c_out=0`, `ovf=0`, `zero=0`.

## Timing
- **Latency:** a beat accepted at rising edge k presents `out_valid=1` after edge k+SEGMENTS-1, i.e. SEGMENTS cycles of stage registers with the output registered. With no stalls, the result is visible SEGMENTS cycles after acceptance.
- **Throughput:** 1 beat/cycle when `out_ready` is held high.
- **Reset timing:** the reset assertion takes effect without a clock edge. The first acceptance is possible at the first rising edge after deassertion (`in_ready=1` during reset release).
- **Critical path:** one SEG_W ripple plus register. For 32/4 this is 8-bit segments.
- **`SEGMENTS=1`:** degenerates to a registered single-cycle add/sub with latency 1.

## Structure
- **Package (`alu_pkg`):**
  - `ADD = 1'b0`, `SUB = 1'b1` mode constants.
  - A function returning signed MAX/MIN for a given width.
- **Sub-module `seg_adder`:** a SEG_W-bit ripple adder with `cin`, `cout` and `c_msb_in` (carry into its top bit), instantiated once per stage by generate loop.
- **Top level:** holds skew registers, the handshake, saturation and the zero accumulation.

## Test plan
All scenarios use WIDTH=32, SEGMENTS=4, `out_ready=1` unless stated.
- **Add, no saturation:** `0x7FFFFFFF+0x00000001`, `sat=0` -> after 4 cycles `sum=0x80000000`, `ovf=1`, `c_out=0`, `zero=0`.
- **Add, saturated:** same operands, `sat=1` -> `sum=0x7FFFFFFF`, `ovf=1`, `c_out=0`.
- **Subtract to zero:** `SUB 5-5` -> `sum=0`, `zero=1`, `c_out=1`, `ovf=0`.
- **Subtract with borrow:** `SUB 0-1` -> `sum=0xFFFFFFFF`, `c_out=0`, `ovf=0`.
- **Subtract, saturated:** `SUB 0x80000000-1`, `sat=1` -> `sum=0x80000000`, `ovf=1`, `c_out=1`.
- **Streaming with stall and reset:**
  - Stimulus: 8 back-to-back beats `i+i` for i=1..8, with `out_ready` low for 3 cycles mid-stream.
  - Required: results 2,4,…,16 in order, none lost; `in_ready` low exactly while stalled; `sum` stable while stalled.
  - Then assert `reset` with 3 beats in flight: `out_valid` drops immediately and no stale result appears afterwards.
